// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage <-> mul/div sequencer bundle: op request and operands in, stall/busy/HI-LO read/commit pulses out.
// The master modport is the pipeline side; the slave modport is the sequencer.
interface ex_muldiv_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] src_s;
    logic [31:0] src_t;
    logic        stall;
    logic        busy;
    logic [31:0] hilo_rdata;
    logic        done;
    logic        div_zero;

    modport master (
        output op_valid, op, flush, src_s, src_t,
        input  stall, busy, hilo_rdata, done, div_zero
    );

    modport slave (
        input  op_valid, op, flush, src_s, src_t,
        output stall, busy, hilo_rdata, done, div_zero
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 1 + 32/STEPS_PER_CYCLE + FIXUP_CYCLES edges to commit.
// Backpressure: stall holds any valid, unflushed EX op while busy; MT/MF complete in the same cycle when idle.
module ex_muldiv_ctrl #(
    parameter int STEPS_PER_CYCLE = 1,
    parameter int FIXUP_CYCLES    = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    ex_muldiv_ctrl_if.slave io_mdu
);
    localparam int         ITERS     = 32 / STEPS_PER_CYCLE;
    localparam logic [5:0] ITER_LAST = 6'(ITERS - 1);
    localparam logic [5:0] FIX_LAST  = 6'(FIXUP_CYCLES - 1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;
    localparam logic [2:0] OP_MFHI = 3'd6;
    localparam logic [2:0] OP_MFLO = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_div_zero;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_dz;

    logic        w_stall;
    logic        w_accept;
    logic        w_signed;
    logic [31:0] w_abs_s;
    logic [31:0] w_abs_t;
    logic [63:0] w_acc_nxt;
    logic [32:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [32:0] w_msum;
    logic [32:0] w_rshift;
    logic [63:0] w_prod;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_unused_rem_msb;

    assign w_stall  = io_mdu.op_valid & ~io_mdu.flush & r_busy;
    assign w_accept = io_mdu.op_valid & ~io_mdu.flush & ~w_stall;

    // Ops 0 (MULT) and 2 (DIV) are the signed forms: op[0] clear.
    assign w_signed = ~io_mdu.op[0];
    assign w_abs_s  = (w_signed & io_mdu.src_s[31]) ? (32'd0 - io_mdu.src_s) : io_mdu.src_s;
    assign w_abs_t  = (w_signed & io_mdu.src_t[31]) ? (32'd0 - io_mdu.src_t) : io_mdu.src_t;

    // One clock retires STEPS_PER_CYCLE bits of both datapaths; only the active one is registered.
    always_comb begin
        w_acc_nxt = r_acc;
        w_rem_nxt = r_rem;
        w_quo_nxt = r_quo;
        w_msum    = '0;
        w_rshift  = '0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            w_msum    = {1'b0, w_acc_nxt[63:32]} + (w_acc_nxt[0] ? {1'b0, r_opnd} : 33'd0);
            w_acc_nxt = {w_msum, w_acc_nxt[31:1]};
            w_rshift  = {w_rem_nxt[31:0], w_quo_nxt[31]};
            w_quo_nxt = {w_quo_nxt[30:0], 1'b0};
            if (w_rshift >= {1'b0, r_opnd}) begin
                w_rem_nxt    = w_rshift - {1'b0, r_opnd};
                w_quo_nxt[0] = 1'b1;
            end else begin
                w_rem_nxt = w_rshift;
            end
        end
    end

    // A zero divisor leaves the dividend magnitude in the remainder, so the sign fix restores src_s.
    assign w_prod    = r_neg_res ? (64'd0 - r_acc) : r_acc;
    assign w_quo_fix = r_dz ? 32'hFFFF_FFFF : (r_neg_res ? (32'd0 - r_quo) : r_quo);
    assign w_rem_fix = r_neg_rem ? (32'd0 - r_rem[31:0]) : r_rem[31:0];

    assign w_unused_rem_msb = r_rem[32];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (io_mdu.op)
                            OP_MTHI: r_hi <= io_mdu.src_s;
                            OP_MTLO: r_lo <= io_mdu.src_s;
                            OP_MFHI, OP_MFLO: begin
                            end
                            default: begin
                                r_busy    <= 1'b1;
                                r_cnt     <= '0;
                                r_is_div  <= io_mdu.op[1];
                                r_neg_res <= w_signed & (io_mdu.src_s[31] ^ io_mdu.src_t[31]);
                                r_neg_rem <= w_signed & io_mdu.src_s[31];
                                r_dz      <= (io_mdu.src_t == 32'd0);
                                r_opnd    <= w_abs_t;
                                r_acc     <= {32'd0, w_abs_s};
                                r_rem     <= '0;
                                r_quo     <= w_abs_s;
                                r_state   <= io_mdu.op[1] ? S_DIV : S_MUL;
                            end
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_state == S_MUL) begin
                        r_acc <= w_acc_nxt;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == ITER_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == FIX_LAST) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_div_zero <= r_is_div & r_dz;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_mdu.stall      = w_stall;
    assign io_mdu.busy       = r_busy;
    assign io_mdu.done       = r_done;
    assign io_mdu.div_zero   = r_div_zero;
    assign io_mdu.hilo_rdata = (io_mdu.op_valid && io_mdu.op == OP_MFHI) ? r_hi :
                               (io_mdu.op_valid && io_mdu.op == OP_MFLO) ? r_lo : 32'd0;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: a vector table of mul/div results plus hand sequences for stall, flush, MT, reset and 2-step latency.
module tb_ex_muldiv_ctrl;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        op_valid;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] src_s;
    logic [31:0] src_t;

    int n_checks;
    int n_fail;

    ex_muldiv_ctrl_if u_if1 ();
    ex_muldiv_ctrl_if u_if2 ();

    assign u_if1.op_valid = op_valid & ~sel;
    assign u_if1.op       = op;
    assign u_if1.flush    = flush;
    assign u_if1.src_s    = src_s;
    assign u_if1.src_t    = src_t;
    assign u_if2.op_valid = op_valid & sel;
    assign u_if2.op       = op;
    assign u_if2.flush    = flush;
    assign u_if2.src_s    = src_s;
    assign u_if2.src_t    = src_t;

    logic        m_stall;
    logic        m_busy;
    logic        m_done;
    logic        m_dz;
    logic [31:0] m_hilo;
    assign m_stall = sel ? u_if2.stall      : u_if1.stall;
    assign m_busy  = sel ? u_if2.busy       : u_if1.busy;
    assign m_done  = sel ? u_if2.done       : u_if1.done;
    assign m_dz    = sel ? u_if2.div_zero   : u_if1.div_zero;
    assign m_hilo  = sel ? u_if2.hilo_rdata : u_if1.hilo_rdata;

    ex_muldiv_ctrl #(.STEPS_PER_CYCLE(1), .FIXUP_CYCLES(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_mdu  (u_if1)
    );

    ex_muldiv_ctrl #(.STEPS_PER_CYCLE(2), .FIXUP_CYCLES(1)) u_dut2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_mdu  (u_if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] s;
        logic [31:0] t;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
        end
    endtask

    // Reads HI then LO combinationally within the current low clock phase.
    task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        op_valid = 1'b1;
        flush    = 1'b0;
        op       = OP_MFHI;
        #1 chk({tag, " HI"}, m_hilo, ehi);
        op = OP_MFLO;
        #1 chk({tag, " LO"}, m_hilo, elo);
        op_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] s, input logic [31:0] t,
                          input int elat, input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        int nb;
        @(negedge clk);
        op_valid = 1'b1;
        flush    = 1'b0;
        op       = o;
        src_s    = s;
        src_t    = t;
        #1 chk({tag, " issue stall"}, {31'd0, m_stall}, 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        nb = 0;
        while (m_busy && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, nb, elat);
        chk({tag, " done"}, {31'd0, m_done}, 32'd1);
        chk({tag, " div_zero"}, {31'd0, m_dz}, {31'd0, edz});
        read_hilo(tag, ehi, elo);
    endtask

    initial begin
        int nb;
        int bad;
        n_checks = 0;
        n_fail   = 0;
        sel      = 1'b0;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        flush    = 1'b0;
        op       = OP_MULT;
        src_s    = '0;
        src_t    = '0;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 33};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[3] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 33};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
        vecs[5] = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 1'b0, 33};
        vecs[6] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 33};
        vecs[7] = '{OP_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 33};
        vecs[8] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800, 1'b0, 33};
        vecs[9] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 33};

        // Reset state
        #2;
        op_valid = 1'b1;
        chk("reset stall", {31'd0, m_stall}, 32'd0);
        chk("reset busy", {31'd0, m_busy}, 32'd0);
        chk("reset done", {31'd0, m_done}, 32'd0);
        chk("reset div_zero", {31'd0, m_dz}, 32'd0);
        read_hilo("reset", 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].s, vecs[i].t,
                   vecs[i].lat, vecs[i].hi, vecs[i].lo, vecs[i].dz);
        end

        // MFLO issued 5 cycles after MULTU: stalls until busy drops, then sees new LO
        @(negedge clk);
        op_valid = 1'b1; op = OP_MULTU; src_s = 32'd3; src_t = 32'd4;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        op_valid = 1'b1; op = OP_MFLO;
        nb = 0; bad = 0;
        while (m_busy && nb < 200) begin
            #1 if (!m_stall) bad++;
            nb++;
            @(negedge clk);
        end
        chk("mflo stall gaps", bad, 0);
        chk("mflo stall cycles", nb, 29);
        #1 chk("mflo stall after", {31'd0, m_stall}, 32'd0);
        chk("mflo rdata", m_hilo, 32'd12);
        op_valid = 1'b0;

        // MTHI/MTLO, and a flushed MTHI leaves HI untouched
        @(negedge clk);
        op_valid = 1'b1; op = OP_MTHI; src_s = 32'h0000_ABCD;
        @(negedge clk);
        op = OP_MFHI;
        #1 chk("mthi write", m_hilo, 32'h0000_ABCD);
        op = OP_MTHI; src_s = 32'h0000_1234; flush = 1'b1;
        #1 chk("flush stall", {31'd0, m_stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0; op = OP_MFHI;
        #1 chk("flushed mthi", m_hilo, 32'h0000_ABCD);
        chk("mt no busy", {31'd0, m_busy}, 32'd0);
        op = OP_MTLO; src_s = 32'h0000_5555;
        @(negedge clk);
        op = OP_MFLO;
        #1 chk("mtlo write", m_hilo, 32'h0000_5555);
        chk("mt no done", {31'd0, m_done}, 32'd0);
        op_valid = 1'b0;

        // Back-to-back: MULT held behind DIVU (first 3 cycles flushed), accepted on the done cycle
        @(negedge clk);
        op_valid = 1'b1; op = OP_DIVU; src_s = 32'd100; src_t = 32'd7;
        @(negedge clk);
        op = OP_MULT; src_s = 32'hFFFF_FFFF; src_t = 32'd5;
        nb = 0; bad = 0;
        while (m_busy && nb < 200) begin
            flush = (nb < 3);
            #1 if (m_stall !== !flush) bad++;
            nb++;
            @(negedge clk);
        end
        flush = 1'b0;
        chk("b2b stall pattern", bad, 0);
        chk("b2b first busy", nb, 33);
        chk("b2b first done", {31'd0, m_done}, 32'd1);
        #1 chk("b2b accept stall", {31'd0, m_stall}, 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        nb = 0;
        while (m_busy && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        chk("b2b second busy", nb, 33);
        read_hilo("b2b mult", 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // Reset mid-DIV aborts and clears HI/LO; next op runs normally
        @(negedge clk);
        op_valid = 1'b1; op = OP_DIV; src_s = 32'd1000; src_t = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("midreset busy", {31'd0, m_busy}, 32'd0);
        chk("midreset done", {31'd0, m_done}, 32'd0);
        read_hilo("midreset", 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post reset div", OP_DIV, 32'd1000, 32'd3, 33, 32'd1, 32'd333, 1'b0);

        // Two bits per cycle
        sel = 1'b1;
        run_op("s2 mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 17, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("s2 div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 17, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("s2 divu0", OP_DIVU, 32'h64, 32'd0, 17, 32'h64, 32'hFFFF_FFFF, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that sits beside the EX stage ALU. It accepts MULT/MULTU/DIV/DIVU from the instruction in EX and runs an iterative shift-add multiply or restoring divide. It owns the HI/LO registers and services MTHI/MTLO/MFHI/MFLO. It raises a stall to the pipeline controller whenever the instruction in EX needs HI/LO or the unit while the unit is busy.

Parameters:
STEPS_PER_CYCLE, 1, iteration bits retired per clock (legal: 1, 2); ITERS = 32/STEPS_PER_CYCLE
FIXUP_CYCLES, 1, sign-correction/commit cycles after iteration (fixed at 1; present for documentation)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
op_valid  in  1  instruction in EX is a mul/div/HI-LO op
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
flush  in  1  squash the EX instruction this cycle
src_s  in  32  rs operand (dividend / multiplicand / MT data)
src_t  in  32  rt operand (divisor / multiplier)
stall  out  1  combinational; EX must hold (its we low)
busy  out  1  registered; iteration or fixup in progress
hilo_rdata  out  32  combinational; HI for MFHI, LO for MFLO, else 0
done  out  1  one-cycle pulse after HI/LO commit
div_zero  out  1  one-cycle pulse with done when divisor was 0

Behaviour:
- Reset (reset=0, async): state IDLE, HI=0, LO=0, busy=0, done=0, div_zero=0, iteration counter=0. Reset mid-operation aborts the op; HI/LO read 0.
- States: IDLE, MUL, DIV, FIXUP.
- accept = op_valid & ~flush & ~stall.
- stall = op_valid & ~flush & busy (any op 0-7). When busy=0, stall=0.
- IDLE, accept of op 0-3 (edge E0):
  - Latch |src_s| and |src_t| (raw values for unsigned ops) and record sign flags.
  - Clear the accumulator, counter=0, busy=1, enter MUL (ops 0/1) or DIV (ops 2/3).
  - The issuing instruction itself does not stall.
- MUL/DIV: each edge retires STEPS_PER_CYCLE bits. After ITERS edges (E1..E_ITERS), go to FIXUP.
- FIXUP, one edge (E_ITERS+1):
  - Apply signs: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI/LO, set busy=0, return to IDLE. done=1 for exactly the following cycle.
- Multiply: HI = product[63:32], LO = product[31:0].
- Divide: LO = quotient, HI = remainder.
- Divisor 0: full latency; LO = 0xFFFFFFFF, HI = src_s; div_zero pulses with done.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0, no div_zero.
- MTHI/MTLO accepted in IDLE: HI/LO written at that edge; no busy, no done.
- MFHI/MFLO: hilo_rdata is valid combinationally while idle and reflects a commit made at the previous edge. No state change.
- flush with op_valid: op ignored, stall=0. flush never cancels an in-flight op.
- New mul/div or MT while busy: stalled until busy=0. It is then accepted in the first IDLE cycle, back-to-back with the done cycle.
- Width rules:
  - Multiply accumulator is 64 bits.
  - Divide uses a 33-bit partial remainder; the restoring subtract compares against {0, divisor}.
  - Counter is 6 bits; wrap impossible.

Test Plan:
- STEPS_PER_CYCLE=1, MULT 0xFFFFFFFE × 0x00000003 -> busy high exactly 33 cycles, done at cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x64 / 0 -> LO=0xFFFFFFFF, HI=0x64, div_zero and done pulse together.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MFLO issued 5 cycles after a MULT -> stall high until busy drops, then hilo_rdata is the new LO.
- MTHI 0x1234 with flush=1 -> HI unchanged.
- reset pulsed low mid-DIV -> busy=0, HI=LO=0 immediately; the next op runs normally.
- STEPS_PER_CYCLE=2 -> MULT latency 17 cycles busy, same results.
